// File: rtl/expu_pipe_ctrl.sv
// Valid/ready to per-register enable controller for the exponential row pipeline.
// Define SOFTEX_EXPU_PIPE_COLLAPSE_EN for bubble collapsing; otherwise the whole pipe stalls together.
module expu_pipe_ctrl #(
    parameter int unsigned NUM_REGS  = 2,
    parameter int unsigned TAG_WIDTH = 1,
    localparam int unsigned EN_W     = (NUM_REGS > 0) ? NUM_REGS : 1,
    localparam int unsigned OCC_W    = (NUM_REGS > 0) ? $clog2(NUM_REGS + 1) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic [EN_W-1:0]      enable_o,
    output logic                 clear_o,
    output logic [OCC_W-1:0]     occupancy_o,
    output logic                 busy_o
);

    assign clear_o = clear_i;

    if (NUM_REGS == 0) begin : g_comb
        // No registers: the handshake passes straight through to the row output.
        assign ready_o     = ready_i;
        assign valid_o     = valid_i;
        assign tag_o       = tag_i;
        assign enable_o    = '0;
        assign occupancy_o = '0;
        assign busy_o      = 1'b0;
    end else begin : g_pipe
        logic [NUM_REGS:1]    v_q;
        logic [TAG_WIDTH-1:0] t_q   [1:NUM_REGS];
        logic [NUM_REGS:0]    v_all;
        logic [TAG_WIDTH-1:0] t_all [0:NUM_REGS];
        logic [NUM_REGS:1]    g;
        logic [NUM_REGS-1:0]  en;
        logic [OCC_W-1:0]     occ;
`ifdef SOFTEX_EXPU_PIPE_COLLAPSE_EN
        logic                 acc;
`endif

        always_comb begin
            v_all    = {v_q, valid_i};
            t_all[0] = tag_i;
            for (int k = 1; k <= int'(NUM_REGS); k++) begin
                t_all[k] = t_q[k];
            end
`ifdef SOFTEX_EXPU_PIPE_COLLAPSE_EN
            // A stage may load when it is empty or when the stage below it can load.
            acc           = ~v_all[NUM_REGS] | ready_i;
            g             = '0;
            g[NUM_REGS]   = acc;
            for (int k = int'(NUM_REGS) - 1; k >= 1; k--) begin
                acc  = ~v_all[k] | acc;
                g[k] = acc;
            end
`else
            g = {NUM_REGS{~v_all[NUM_REGS] | ready_i}};
`endif
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                en[i] = v_all[i] & g[i+1] & ~clear_i;
            end
        end

        always_comb begin
            occ = '0;
            for (int k = 1; k <= int'(NUM_REGS); k++) begin
                occ = occ + OCC_W'(v_q[k]);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni || clear_i) begin
                v_q <= '0;
                for (int k = 1; k <= int'(NUM_REGS); k++) begin
                    t_q[k] <= '0;
                end
            end else begin
                for (int k = 1; k <= int'(NUM_REGS); k++) begin
                    if (g[k]) v_q[k] <= v_all[k-1];
                    if (en[k-1]) t_q[k] <= t_all[k-1];
                end
            end
        end

        assign ready_o     = g[1] & ~clear_i;
        assign valid_o     = v_q[NUM_REGS];
        assign tag_o       = t_q[NUM_REGS];
        assign enable_o    = en;
        assign occupancy_o = occ;
        assign busy_o      = |v_q;
    end

endmodule
